ge_cell: RTL and testbench
==========================

GE_CELL -- requirements
Module: ge_cell

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand width in bits (legal range 1..32).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-005 Port a: input, WIDTH bits, left operand.
REQ-006 Port b: input, WIDTH bits, right operand.
REQ-007 Port in_valid: input, 1 bit, marks a/b as a valid compare request this cycle.
REQ-008 Port out: output, WIDTH-independent 1 bit, registered result of a >= b.
REQ-009 Port gt: output, 1 bit, registered result of a > b.
REQ-010 Port eq: output, 1 bit, registered result of a == b.
REQ-011 Port out_valid: output, 1 bit, high for exactly one cycle per accepted request.
REQ-012 Port sgn (present only with GE_CELL_SIGNED_EN): input, 1 bit; 1 means signed operands, 0 means unsigned operands.

Function
REQ-013 Default comparison SHALL be unsigned and full-width, with no truncation or extension.
REQ-014 Latency SHALL be exactly 1 cycle: a request sampled at edge N drives out/gt/eq/out_valid after edge N.
REQ-015 Results SHALL satisfy out = gt | eq; gt and eq SHALL never be high together.
REQ-016 When in_valid=0 at an edge, out_valid SHALL go to 0 and out/gt/eq SHALL hold their previous values.
REQ-017 Back-to-back requests SHALL be accepted every cycle with no bubbles and no backpressure.
REQ-018 Boundary cases: a=b=0 gives out=1, eq=1, gt=0; a=all-ones, b=0 gives out=1, gt=1; a=0, b=all-ones gives out=0.
REQ-019 The compare SHALL be implemented as a MSB-first cascade of per-bit gt/eq cells, combined in one combinational stage before the output register.

Reset
REQ-020 While rst_n=0, out, gt, eq and out_valid SHALL be 0, regardless of clk.
REQ-021 Reset assertion SHALL take effect immediately (asynchronous); deassertion SHALL be synchronized to clk internally.
REQ-022 The first request SHALL be accepted at the first rising edge after deassertion completes.
REQ-023 A request in flight when reset asserts SHALL be discarded, with no out_valid pulse after reset.

Configuration
REQ-024 Macro GE_CELL_SIGNED_EN SHALL control signed-compare support.
REQ-025 With GE_CELL_SIGNED_EN defined, the sgn port SHALL exist; when sgn=1, operands are compared as two's complement.
REQ-026 In signed mode, with WIDTH=4: a=4'hF (-1), b=4'h1 gives out=0; a=4'h8 (-8) compared with any b gives out=1 only if b=4'h8.
REQ-027 Without GE_CELL_SIGNED_EN, there SHALL be no sgn port and no signed logic, and behaviour SHALL be the unsigned compare only.

Verification
REQ-028 With WIDTH=4, apply in_valid=1 every cycle with (a,b) = (0,0), (2,0), (3,1), (4,6), (3,2). Required out sequence one cycle later: 1, 1, 1, 0, 1; eq sequence: 1, 0, 0, 0, 0.
REQ-029 Hold in_valid=0 after a request with (5,5). Required: out=1 and eq=1 are held, and out_valid pulses exactly once.
REQ-030 Assert rst_n=0 mid-cycle while out=1. Required: out, gt, eq and out_valid go to 0 immediately, before the next clk edge.
REQ-031 Apply a=15, b=0, then a=0, b=15. Required: out=1, gt=1, then out=0, gt=0, eq=0.
REQ-032 With GE_CELL_SIGNED_EN and sgn=1, apply (a,b) = (4'hF, 4'h1). Required: out=0. With sgn=0 and the same operands, required: out=1.
REQ-033 Run a randomized sweep of all 256 (a,b) pairs. Required: out, gt and eq match the arithmetic reference with one-cycle latency, and out = gt | eq always.

Source files
------------

// File: rtl/ge_cell.sv
// ge_cell: registered a >= b comparator (with gt/eq flags), 1-cycle latency, built from an MSB-first bit cascade.
// Define GE_CELL_SIGNED_EN to add the sgn port and a two's-complement compare mode.
module ge_cell #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef GE_CELL_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             out,
  output logic             gt,
  output logic             eq,
  output logic             out_valid
);

  logic [1:0]       rstSync_q;
  logic             rstIntN;
  logic [WIDTH-1:0] bitGt;
  logic [WIDTH-1:0] bitEq;
  logic             gtAcc;
  logic             eqAcc;
  logic             gt_d;
  logic             eq_d;
  logic             out_d;
  logic             gt_q;
  logic             eq_q;
  logic             out_q;
  logic             outValid_q;

  // Reset asserts at once, but is released only after two clean clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstSync_q <= 2'b00;
    end else begin
      rstSync_q <= {rstSync_q[0], 1'b1};
    end
  end

  assign rstIntN = rstSync_q[1];

  // Per-bit cells; in signed mode the sign bit's "greater" sense is inverted.
  always_comb begin
    bitGt = a & ~b;
    bitEq = ~(a ^ b);
`ifdef GE_CELL_SIGNED_EN
    if (sgn) begin
      bitGt[WIDTH-1] = ~a[WIDTH-1] & b[WIDTH-1];
    end
`endif
    gtAcc = 1'b0;
    eqAcc = 1'b1;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      gtAcc = gtAcc | (eqAcc & bitGt[i]);
      eqAcc = eqAcc & bitEq[i];
    end
    gt_d  = gtAcc;
    eq_d  = eqAcc;
    out_d = gtAcc | eqAcc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      out_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else if (!rstIntN) begin
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      out_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      outValid_q <= in_valid;
      if (in_valid) begin
        gt_q  <= gt_d;
        eq_q  <= eq_d;
        out_q <= out_d;
      end
    end
  end

  assign out       = out_q;
  assign gt        = gt_q;
  assign eq        = eq_q;
  assign out_valid = outValid_q;

endmodule

// File: tb/tb_ge_cell.sv
// tb_ge_cell: directed and shuffled-exhaustive checks of ge_cell at WIDTH=4.
// Signed-mode steps are compiled in only when GE_CELL_SIGNED_EN is defined.
module tb_ge_cell;

  logic       clk;
  logic       rst_n;
  logic       sgn;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic       out;
  logic       gt;
  logic       eq;
  logic       out_valid;

  int checks;
  int errors;

  ge_cell #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef GE_CELL_SIGNED_EN
    .sgn       (sgn),
`endif
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .out       (out),
    .gt        (gt),
    .eq        (eq),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, then sample 1ns after the next rising edge.
  task automatic applyStimulus(input logic [3:0] av, input logic [3:0] bv, input logic v);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic eOut, input logic eGt,
                          input logic eEq, input logic eVal);
    checkOutput({tag, ".out"}, out, eOut);
    checkOutput({tag, ".gt"}, gt, eGt);
    checkOutput({tag, ".eq"}, eq, eEq);
    checkOutput({tag, ".out_valid"}, out_valid, eVal);
  endtask

  logic [3:0] seqA   [5] = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd3};
  logic [3:0] seqB   [5] = '{4'd0, 4'd0, 4'd1, 4'd6, 4'd2};
  logic       seqOut [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic       seqEq  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       seqGt  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int         perm   [256];

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    sgn      = 1'b0;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;

    #2;
    checkAll("reset_state", 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_after_release.out_valid", out_valid, 1'b0);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(seqA[k], seqB[k], 1'b1);
      checkAll($sformatf("seq%0d", k), seqOut[k], seqGt[k], seqEq[k], 1'b1);
    end

    applyStimulus(4'd5, 4'd5, 1'b1);
    checkAll("req_5_5", 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'd0, 4'd15, 1'b0);
    checkAll("hold1", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'd1, 4'd9, 1'b0);
    checkAll("hold2", 1'b1, 1'b0, 1'b1, 1'b0);

    applyStimulus(4'd15, 4'd0, 1'b1);
    checkAll("max_vs_0", 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus(4'd0, 4'd15, 1'b1);
    checkAll("0_vs_max", 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef GE_CELL_SIGNED_EN
    sgn = 1'b1;
    applyStimulus(4'hF, 4'h1, 1'b1);
    checkAll("signed_m1_vs_1", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h8, 4'h8, 1'b1);
    checkAll("signed_m8_vs_m8", 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'h8, 4'h7, 1'b1);
    checkAll("signed_m8_vs_7", 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'h8, 4'hF, 1'b1);
    checkAll("signed_m8_vs_m1", 1'b0, 1'b0, 1'b0, 1'b1);
    sgn = 1'b0;
    applyStimulus(4'hF, 4'h1, 1'b1);
    checkAll("unsigned_15_vs_1", 1'b1, 1'b1, 1'b0, 1'b1);
`endif

    for (int k = 0; k < 256; k++) perm[k] = k;
    for (int k = 255; k > 0; k--) begin
      int j;
      int t;
      j       = int'($urandom_range(k, 0));
      t       = perm[k];
      perm[k] = perm[j];
      perm[j] = t;
    end
    for (int k = 0; k < 256; k++) begin
      logic [7:0] pr;
      int         ai;
      int         bi;
      pr = perm[k][7:0];
      ai = int'(pr[7:4]);
      bi = int'(pr[3:0]);
      applyStimulus(pr[7:4], pr[3:0], 1'b1);
      checkAll($sformatf("sweep_%0d_%0d", ai, bi), ai >= bi, ai > bi, ai == bi, 1'b1);
      checkOutput($sformatf("sweep_%0d_%0d.or", ai, bi), out, gt | eq);
    end

    applyStimulus(4'd5, 4'd3, 1'b1);
    checkAll("pre_reset", 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    a        = 4'd7;
    b        = 4'd1;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkAll("in_reset_edge", 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkAll("no_stale_pulse", 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'd2, 4'd2, 1'b1);
    checkAll("first_after_reset", 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'd2, 4'd2, 1'b0);
    checkOutput("single_pulse.out_valid", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
